// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
//   state_e  : arbiter FSM states (IDLE, ACC_CPU, ACC_IO)
//   req_id_e : requester identity, used for round-robin history
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACC_CPU = 2'd1,
      ACC_IO  = 2'd2
   } state_e;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_IO  = 1'b1
   } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector.
//   i_req_cpu, i_req_io : candidate request bits
//   i_last_gnt          : requester served most recently
//   o_valid             : at least one candidate present
//   o_sel               : chosen requester (meaningful only when o_valid)
module rr_arbiter2
   import dmem_arb_pkg::*;
(
   input  logic    i_req_cpu,
   input  logic    i_req_io,
   input  req_id_e i_last_gnt,
   output logic    o_valid,
   output req_id_e o_sel
);

   always_comb begin
      o_valid = i_req_cpu | i_req_io;
      o_sel   = REQ_CPU;
      if (i_req_cpu && i_req_io) begin
         // Tie goes to whoever was not served last.
         o_sel = (i_last_gnt == REQ_CPU) ? REQ_IO : REQ_CPU;
      end else if (i_req_io) begin
         o_sel = REQ_IO;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a single-port data memory between a CPU and an IO/DMA requester.
//   i_clk, i_reset              : clock, synchronous active-low reset
//   i_cpu_* / o_cpu_*           : CPU request, grant and read-return channel
//   i_io_*  / o_io_*            : IO/DMA request, grant and read-return channel
//   o_mem_we/addr/wdata         : memory command, driven in the grant cycle
//   i_mem_rdata                 : combinational memory read data
// A request sampled in one cycle is granted the next; read data returns the
// cycle after the grant from a per-requester register.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_cpu_req,
   input  logic             i_cpu_we,
   input  logic [WIDTH-1:0] i_cpu_addr,
   input  logic [WIDTH-1:0] i_cpu_wdata,
   output logic             o_cpu_gnt,
   output logic             o_cpu_rvalid,
   output logic [WIDTH-1:0] o_cpu_rdata,
   input  logic             i_io_req,
   input  logic             i_io_we,
   input  logic [WIDTH-1:0] i_io_addr,
   input  logic [WIDTH-1:0] i_io_wdata,
   output logic             o_io_gnt,
   output logic             o_io_rvalid,
   output logic [WIDTH-1:0] o_io_rdata,
   output logic             o_mem_we,
   output logic [WIDTH-1:0] o_mem_addr,
   output logic [WIDTH-1:0] o_mem_wdata,
   input  logic [WIDTH-1:0] i_mem_rdata
);

   state_e           r_state;
   state_e           w_state_next;
   req_id_e          r_last_gnt;
   logic             r_cpu_rvalid;
   logic             r_io_rvalid;
   logic [WIDTH-1:0] r_cpu_rdata;
   logic [WIDTH-1:0] r_io_rdata;

   logic             w_cpu_served;
   logic             w_io_served;
   logic             w_arb_cpu;
   logic             w_arb_io;
   logic             w_arb_valid;
   req_id_e          w_arb_sel;

   // An access happens only if the scheduled requester still holds its
   // request; a request dropped before its grant cycle is discarded. Reset
   // low also kills the access so no write can slip through.
   assign w_cpu_served = (r_state == ACC_CPU) && i_cpu_req && i_reset;
   assign w_io_served  = (r_state == ACC_IO)  && i_io_req  && i_reset;

   // The requester occupying the current cycle sits out arbitration, so a
   // held request from it cannot be granted twice for one access.
   assign w_arb_cpu = i_cpu_req && (r_state != ACC_CPU);
   assign w_arb_io  = i_io_req  && (r_state != ACC_IO);

   rr_arbiter2 u_rr_arbiter2 (
      .i_req_cpu  (w_arb_cpu),
      .i_req_io   (w_arb_io),
      .i_last_gnt (r_last_gnt),
      .o_valid    (w_arb_valid),
      .o_sel      (w_arb_sel)
   );

   always_comb begin
      w_state_next = IDLE;
      if (w_arb_valid) begin
         w_state_next = (w_arb_sel == REQ_CPU) ? ACC_CPU : ACC_IO;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state      <= IDLE;
         r_last_gnt   <= REQ_IO;
         r_cpu_rvalid <= 1'b0;
         r_io_rvalid  <= 1'b0;
         r_cpu_rdata  <= '0;
         r_io_rdata   <= '0;
      end else begin
         r_state      <= w_state_next;
         r_cpu_rvalid <= w_cpu_served && !i_cpu_we;
         r_io_rvalid  <= w_io_served && !i_io_we;
         if (w_cpu_served) begin
            r_last_gnt <= REQ_CPU;
         end else if (w_io_served) begin
            r_last_gnt <= REQ_IO;
         end
         if (w_cpu_served && !i_cpu_we) begin
            r_cpu_rdata <= i_mem_rdata;
         end
         if (w_io_served && !i_io_we) begin
            r_io_rdata <= i_mem_rdata;
         end
      end
   end

   always_comb begin
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      if (w_cpu_served) begin
         o_mem_we    = i_cpu_we;
         o_mem_addr  = i_cpu_addr;
         o_mem_wdata = i_cpu_wdata;
      end else if (w_io_served) begin
         o_mem_we    = i_io_we;
         o_mem_addr  = i_io_addr;
         o_mem_wdata = i_io_wdata;
      end
   end

   assign o_cpu_gnt    = w_cpu_served;
   assign o_io_gnt     = w_io_served;
   assign o_cpu_rvalid = r_cpu_rvalid;
   assign o_io_rvalid  = r_io_rvalid;
   assign o_cpu_rdata  = r_cpu_rdata;
   assign o_io_rdata   = r_io_rdata;

endmodule
